// File: rtl/arm_regstore.sv
// arm_regstore: 31 x WIDTH architectural register storage with a hard-wired
// zero register (XZR, index 31), one write port and write-first forwarding
// onto a bit-transposed bus feeding the read-port mux banks.
module arm_regstore #(
  parameter int WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    RegWrite,
  input  logic [4:0]              WriteRegister,
  input  logic [WIDTH-1:0]        WriteData,
  output logic [WIDTH-1:0][31:0]  regs,
  output logic [31:0][WIDTH-1:0]  stored,
  output logic [15:0]             wr_count
);

  logic [31:0]            we;
  logic [30:0][WIDTH-1:0] store_q, store_d;
  logic [15:0]            wr_count_q, wr_count_d;

  // One-hot write enable; XZR never gets an enable so it can never be written.
  always_comb begin
    we = '0;
    if (RegWrite) begin
      we[WriteRegister] = 1'b1;
    end
    we[31] = 1'b0;
  end

  // Next-state: the enabled register loads WriteData, the count tracks commits.
  always_comb begin
    store_d    = store_q;
    wr_count_d = wr_count_q;
    for (int r = 0; r < 31; r++) begin
      if (we[r]) begin
        store_d[r] = WriteData;
      end
    end
    if (|we) begin
      wr_count_d = wr_count_q + 16'd1;
    end
  end

  // Storage flops and write counter, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      store_q    <= '0;
      wr_count_q <= '0;
    end else begin
      store_q    <= store_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Raw view plus transposed, write-first forwarded bus; XZR reads as zero.
  always_comb begin
    stored[31]   = '0;
    stored[30:0] = store_q;
    for (int i = 0; i < WIDTH; i++) begin
      regs[i][31] = 1'b0;
      for (int r = 0; r < 31; r++) begin
        regs[i][r] = we[r] ? WriteData[i] : store_q[r][i];
      end
    end
  end

  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_arm_regstore.sv
// tb_arm_regstore: randomized and directed checks of arm_regstore against a
// behavioural array model of the register file.
module tb_arm_regstore;

  logic                clk;
  logic                reset_n;
  logic                RegWrite;
  logic [4:0]          WriteRegister;
  logic [63:0]         WriteData;
  logic [63:0][31:0]   regs;
  logic [31:0][63:0]   stored;
  logic [15:0]         wr_count;

  logic [63:0] model_regs [32];
  int          model_count;
  int          test_count;
  int          fail_count;

  arm_regstore #(.WIDTH(64)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .regs          (regs),
    .stored        (stored),
    .wr_count      (wr_count)
  );

  // Free-running clock, posedges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", tag, actual, expected);
    end
  endtask

  // Gather register r from the transposed bus.
  function automatic logic [63:0] reg_column(input int r);
    logic [63:0] v;
    for (int i = 0; i < 64; i++) v[i] = regs[i][r];
    return v;
  endfunction

  // What the read bus should show for register r given the current inputs.
  function automatic logic [63:0] bus_expect(input int r);
    if (r == 31) return 64'd0;
    if (RegWrite && int'(WriteRegister) == r) return WriteData;
    return model_regs[r];
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < 32; r++) model_regs[r] = 64'd0;
    model_count = 0;
  endfunction

  // Architectural effect of one clock edge.
  function automatic void model_edge();
    if (reset_n && RegWrite && WriteRegister != 5'd31) begin
      model_regs[WriteRegister] = WriteData;
      model_count = (model_count + 1) % 65536;
    end
  endfunction

  task automatic check_bus(input string tag);
    for (int r = 0; r < 32; r++)
      checkOutput($sformatf("%s regs[*][%0d]", tag, r), reg_column(r), bus_expect(r));
  endtask

  task automatic check_state(input string tag);
    for (int r = 0; r < 32; r++)
      checkOutput($sformatf("%s stored[%0d]", tag, r), stored[r], model_regs[r]);
    checkOutput($sformatf("%s wr_count", tag), 64'(wr_count), 64'(model_count));
  endtask

  // Drive one cycle (entered at posedge+1), check forwarding before the edge
  // and committed state after it.
  task automatic applyStimulus(input logic wen, input logic [4:0] idx,
                               input logic [63:0] data, input string tag);
    RegWrite      = wen;
    WriteRegister = idx;
    WriteData     = data;
    #2;
    check_bus({tag, " pre"});
    check_state({tag, " pre"});
    @(posedge clk);
    model_edge();
    #1;
    check_state({tag, " post"});
  endtask

  initial begin
    test_count    = 0;
    fail_count    = 0;
    reset_n       = 1'b0;
    RegWrite      = 1'b0;
    WriteRegister = 5'd0;
    WriteData     = 64'd0;
    model_clear();

    // Reset state
    #1;
    check_bus("reset");
    check_state("reset");
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Write/readback on consecutive cycles
    applyStimulus(1'b1, 5'd0,  64'h1, "wr x0");
    applyStimulus(1'b1, 5'd7,  64'hFFFF_FFFF_FFFF_FFFF, "wr x7");
    applyStimulus(1'b1, 5'd30, 64'h8000_0000_0000_0000, "wr x30");
    RegWrite = 1'b0;
    #1;
    checkOutput("regs[63][30]", 64'(regs[63][30]), 64'd1);
    checkOutput("regs[0][7]", 64'(regs[0][7]), 64'd1);
    checkOutput("wr_count after 3", 64'(wr_count), 64'd3);
    #1;

    // XZR writes are discarded
    applyStimulus(1'b1, 5'd31, 64'h1234, "xzr");
    checkOutput("xzr column", reg_column(31), 64'd0);

    // Forwarding: hold shows old value, write shows new value before the edge
    applyStimulus(1'b1, 5'd3, 64'hAA, "fw setup");
    applyStimulus(1'b0, 5'd3, 64'h55, "fw hold");
    applyStimulus(1'b1, 5'd3, 64'h55, "fw write");

    // Hold: RegWrite low with random address/data
    for (int k = 0; k < 10; k++)
      applyStimulus(1'b0, 5'($urandom_range(0, 31)), {$urandom, $urandom}, "hold");

    // Randomized traffic
    for (int k = 0; k < 150; k++)
      applyStimulus(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                    {$urandom, $urandom}, "rand");

    // Sweep all writable indices with unique patterns, then confirm no aliasing
    for (int r = 0; r < 31; r++)
      applyStimulus(1'b1, 5'(r), {8'(r), 24'h5A5A00 | 24'(r), ~32'(r)}, "sweep");
    RegWrite = 1'b0;
    #1;
    check_bus("sweep final");

    // Mid-cycle asynchronous reset after X5 = 0xDEAD
    applyStimulus(1'b1, 5'd5, 64'hDEAD, "dead");
    RegWrite = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    model_clear();
    check_bus("async reset");
    check_state("async reset");

    // A write presented during reset forwards but does not commit
    RegWrite      = 1'b1;
    WriteRegister = 5'd4;
    WriteData     = 64'hBEEF;
    #1;
    check_bus("wr in reset");
    @(posedge clk);
    model_edge();
    #1;
    check_state("wr in reset post");
    RegWrite = 1'b0;
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 5'd4, 64'hC0DE, "first after reset");

    // Counter wrap: count is 1 here, so 65535 more writes reach 0
    for (int k = 0; k < 65535; k++) begin
      RegWrite      = 1'b1;
      WriteRegister = 5'd1;
      WriteData     = {$urandom, $urandom};
      @(posedge clk);
      model_edge();
      #1;
    end
    checkOutput("wr_count wrapped", 64'(wr_count), 64'd0);
    applyStimulus(1'b1, 5'd1, {$urandom, $urandom}, "post wrap");
    checkOutput("wr_count after wrap", 64'(wr_count), 64'd1);
    checkOutput("x1 last data", stored[1], WriteData);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/arm_regstore.md
# arm_regstore

Storage stage of the ARM register file. It holds 32 architectural registers of WIDTH bits (X0–X30 plus XZR) and writes one register per clock. It drives the bit-transposed bus that the two 32:1 read-port mux banks consume: `regs[i][r]` is bit i of register r. A same-cycle write is forwarded onto the bus, so a read of the register being written returns the new value (write-first).

## Interface
- `WIDTH`, default 64: register width in bits.
- `clk`  input  1  single clock; all state updates on posedge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `RegWrite`  input  1  write enable for this cycle.
- `WriteRegister`  input  5  destination register index, 0–31.
- `WriteData`  input  WIDTH  value to write.
- `regs`  output  [WIDTH-1:0][31:0]  transposed register bus; `regs[i][r]` = bit i of register r, forwarding applied.
- `stored`  output  [31:0][WIDTH-1:0]  raw flop contents, register-major, no forwarding (debug/verification view).
- `wr_count`  output  16  count of committed writes since reset; wraps at 0xFFFF→0.

## Operation
- Storage: 31 WIDTH-bit registers for indices 0–30. Index 31 is XZR and has no flops.
- Write decode: a 5:32 one-hot decoder on `WriteRegister`, gated by `RegWrite`, gives `we[31:0]`. `we[31]` is always forced to 0.
- Commit: at posedge `clk`, if `we[r]=1`, register r loads `WriteData`. All other registers hold.
- XZR: `stored[31]` and `regs[*][31]` are always 0. Writes to 31 are discarded and do not increment `wr_count`.
- Forwarding, combinational: `regs[i][r] = we[r] ? WriteData[i] : stored[r][i]`.
  - This creates a combinational path from `WriteData`/`WriteRegister`/`RegWrite` to `regs`.
  - `regs` equals the transposed `stored` whenever `RegWrite=0`.
- `wr_count` increments by 1 on each posedge where `RegWrite=1` and `WriteRegister≠31`.
- Width rules:
  - `WriteData` is stored unmodified. No sign extension or truncation happens here.
  - `wr_count` is unsigned modulo 2^16.

## Timing
- Reset: while `reset_n=0`, asynchronously and immediately:
  - all `stored` = 0 and `wr_count` = 0;
  - `regs` = 0 for every register except the one currently forwarded by `we`.
- Reset deassertion is synchronous to the design. The first write can commit on the first posedge after `reset_n` rises.
- A write asserted during reset is not committed. When reset falls mid-write, it wins and the register stays 0.
- Write latency:
  - `regs` reflects the new value in the same cycle (forwarding).
  - `stored` reflects it after the posedge, and it stays visible in `regs` from the next cycle onward with no forwarding.
- Back-to-back writes to the same register: each posedge commits the value presented in that cycle, so the last one wins. There are no stalls and no hazards inside the block.
- Simultaneous events: only one write port exists, so no write-write collision is possible.
- Inputs must be stable before posedge by the flop setup time. The forwarding path delay adds to the downstream mux delay in the read-path timing budget.

## Test plan
- Reset: drive `reset_n=0` mid-simulation after writes of 0xDEAD to X5 -> `stored[5]=0`, `wr_count=0`, all `regs` bits 0, asynchronously before the next edge.
- Write/readback: write X0=0x1, X7=0xFFFF_FFFF_FFFF_FFFF, X30=0x8000_0000_0000_0000 on consecutive cycles -> `stored` matches after each edge, `regs[63][30]=1`, `regs[0][7]=1`, `wr_count=3`.
- XZR: `RegWrite=1`, `WriteRegister=31`, `WriteData=0x1234` -> `regs[*][31]=0` in the same cycle and after the edge, `wr_count` unchanged.
- Forwarding: X3 holds 0xAA; in one cycle drive `RegWrite=1`, `WriteRegister=3`, `WriteData=0x55` -> `regs[*][3]` shows 0x55 before the edge and `stored[3]=0xAA` until the edge. With `RegWrite=0` and the same data, `regs` shows 0xAA.
- Hold: `RegWrite=0` for 10 cycles with random `WriteRegister`/`WriteData` -> no change in `stored` or `wr_count`.
- Counter wrap: perform 65537 writes to X1 -> `wr_count=1`, `stored[1]` equals the last `WriteData`. Also sweep all indices 0–30 with unique patterns and confirm there is no aliasing.
